reset_request_gen: RTL and testbench

//  Reset-request front end that drives the `start` input of the boot reset counter stage.
//  It merges three reset sources into one clean single-cycle start_o pulse:
//   - controller command pulse
//   - debounced external button
//   - core watchdog timeout
//  It records which source fired, watches the resulting reset_o handshake, and enforces a holdoff before re-arming.

---
 rtl/reset_request_gen.sv | 213 +++++++++++++++++++++
 tb/tb_reset_request_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_request_gen.sv
// reset_request_gen
// Merges the controller command, the debounced reset button and the core
// watchdog into a single one-cycle start pulse for the boot reset stage. It
// records which sources fired, follows the reset_o handshake coming back from
// that stage, and waits out a holdoff period before it accepts new requests.
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// ST_IDLE         | armed; any request moves to ST_FIRE and latches the cause
// ST_FIRE         | start_o high for this one cycle
// ST_WAIT_ASSERT  | waiting for core_reset_i; re-fires after 4 cycles without it
// ST_WAIT_RELEASE | downstream reset is active; wait for it to drop
// ST_HOLDOFF      | HOLDOFF_CYCLES idle cycles before re-arming
module reset_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WDT_TIMEOUT     = 1000000,
  parameter int unsigned WDT_W           = 32,
  parameter int unsigned HOLDOFF_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_i,
  input  logic       cmd_reset_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  input  logic       core_reset_i,
  output logic       start_o,
  output logic [2:0] cause_o,
  output logic       busy_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HO_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

  // FIRE plus four WAIT_ASSERT cycles gives a re-pulse every five cycles.
  localparam logic [1:0] AW_LOAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_ASSERT,
    ST_WAIT_RELEASE,
    ST_HOLDOFF
  } state_t;

  state_t state;
  state_t state_n;

  logic            btn_s1;
  logic            btn_s2;
  logic            btn_db;
  logic            btn_db_q;
  logic [DB_W-1:0] db_cnt;
  logic            btn_req;

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_hit;
  logic             wdt_clr;

  logic            core_q;
  logic            core_rise;
  logic [1:0]      aw_cnt;
  logic [HO_W-1:0] ho_cnt;

  logic            any_req;
  logic            in_idle;

  assign in_idle   = (state == ST_IDLE);
  assign btn_req   = btn_db & ~btn_db_q;
  assign core_rise = core_reset_i & ~core_q;

  // Watchdog expiry only counts in IDLE; a kick in the expiry cycle wins.
  assign wdt_hit = wdt_en_i & ~wdt_kick_i & in_idle & (wdt_cnt == WDT_LAST);
  assign wdt_clr = ~wdt_en_i | wdt_kick_i | ~in_idle | wdt_hit;

  assign any_req = cmd_reset_i | btn_req | wdt_hit;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= button_i;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Watchdog counter: runs only while enabled, unkicked and armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if (wdt_clr) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  // Previous core_reset_i, used to spot downstream re-entering reset during holdoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_q <= 1'b0;
    end else begin
      core_q <= core_reset_i;
    end
  end

  // Assert-wait timer: loaded while firing, counts down in WAIT_ASSERT.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_cnt <= '0;
    end else if (state == ST_FIRE) begin
      aw_cnt <= AW_LOAD;
    end else if ((state == ST_WAIT_ASSERT) && (aw_cnt != 2'd0)) begin
      aw_cnt <= aw_cnt - 2'd1;
    end
  end

  // Holdoff counter: zero outside HOLDOFF, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ho_cnt <= '0;
    end else if (state != ST_HOLDOFF) begin
      ho_cnt <= '0;
    end else if (ho_cnt != HO_LAST) begin
      ho_cnt <= ho_cnt + HO_W'(1);
    end
  end

  // Sticky cause: captured only when leaving IDLE, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_o <= 3'b000;
    end else if (in_idle && any_req) begin
      cause_o <= {wdt_hit, btn_req, cmd_reset_i};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_n = state;
    start_o = 1'b0;
    busy_o  = 1'b1;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (any_req) begin
          state_n = ST_FIRE;
        end
      end
      ST_FIRE: begin
        start_o = 1'b1;
        state_n = ST_WAIT_ASSERT;
      end
      ST_WAIT_ASSERT: begin
        if (core_reset_i) begin
          state_n = ST_WAIT_RELEASE;
        end else if (aw_cnt == 2'd0) begin
          state_n = ST_FIRE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!core_reset_i) begin
          state_n = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (core_rise) begin
          state_n = ST_WAIT_RELEASE;
        end else if (ho_cnt == HO_LAST) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed bench for reset_request_gen. A simple downstream model raises
// core_reset_i the cycle after each start pulse and holds it for CORE_LEN
// cycles; each scenario records start/busy timing relative to its own cycle 0.
module tb_reset_request_gen;

  localparam int CORE_LEN = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_i;
  logic       cmd_reset_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic       core_reset_i;
  logic       start_o;
  logic [2:0] cause_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;
  int c;
  int n_start;
  int first_start;
  int last_start;
  int last_busy;
  int core_cnt;
  bit model_en;

  always #5 clk = ~clk;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(16),
    .WDT_TIMEOUT    (100),
    .WDT_W          (8),
    .HOLDOFF_CYCLES (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_i    (button_i),
    .cmd_reset_i (cmd_reset_i),
    .wdt_en_i    (wdt_en_i),
    .wdt_kick_i  (wdt_kick_i),
    .core_reset_i(core_reset_i),
    .start_o     (start_o),
    .cause_o     (cause_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drive the downstream model and record output events.
  task automatic tick();
    @(posedge clk);
    #1;
    c++;
    core_reset_i = (core_cnt > 0);
    if (core_cnt > 0) core_cnt--;
    if (start_o) begin
      n_start++;
      if (first_start < 0) first_start = c;
      last_start = c;
      if (model_en) core_cnt = CORE_LEN;
    end
    if (busy_o) last_busy = c;
  endtask

  task automatic apply_reset();
    button_i     = 1'b0;
    cmd_reset_i  = 1'b0;
    wdt_en_i     = 1'b0;
    wdt_kick_i   = 1'b0;
    core_reset_i = 1'b0;
    core_cnt     = 0;
    reset        = 1'b1;
    tick();
    tick();
    reset       = 1'b0;
    c           = 0;
    n_start     = 0;
    first_start = -1;
    last_start  = -1;
    last_busy   = -1;
  endtask

  initial begin
    model_en     = 1'b1;
    c            = 0;
    reset        = 1'b1;
    button_i     = 1'b0;
    cmd_reset_i  = 1'b0;
    wdt_en_i     = 1'b0;
    wdt_kick_i   = 1'b0;
    core_reset_i = 1'b0;

    // Reset values.
    apply_reset();
    check("rst_start", 32'(start_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cause", 32'(cause_o), 0);

    // Command at 10: start only in 11, handshake 12..31, busy through 64.
    while (c < 80) begin
      cmd_reset_i = (c == 10);
      tick();
    end
    check("cmd_n_start", n_start, 1);
    check("cmd_start_cycle", first_start, 11);
    check("cmd_cause", 32'(cause_o), 1);
    check("cmd_last_busy", last_busy, 64);

    // Bouncy button settles high at 39 -> start at 58; release later never fires.
    apply_reset();
    while (c < 220) begin
      if (c < 40) button_i = ((c / 3) % 2 == 1);
      else        button_i = (c < 160);
      tick();
    end
    check("btn_n_start", n_start, 1);
    check("btn_start_cycle", first_start, 58);
    check("btn_cause", 32'(cause_o), 2);
    check("btn_last_busy", last_busy, 111);

    // Watchdog enabled at 0, never kicked -> start at 100.
    apply_reset();
    while (c < 110) begin
      wdt_en_i = 1'b1;
      tick();
    end
    check("wdt_n_start", n_start, 1);
    check("wdt_start_cycle", first_start, 100);
    check("wdt_cause", 32'(cause_o), 4);

    // Kicks every 50 cycles keep the watchdog quiet.
    apply_reset();
    while (c < 300) begin
      wdt_en_i   = 1'b1;
      wdt_kick_i = (c % 50 == 49);
      tick();
    end
    check("wdt_kick_n_start", n_start, 0);
    check("wdt_kick_busy", 32'(busy_o), 0);

    // Kick in the expiry cycle wins; watchdog then fires a full period later.
    apply_reset();
    while (c < 210) begin
      wdt_en_i   = 1'b1;
      wdt_kick_i = (c == 99);
      tick();
    end
    check("wdt_edge_n_start", n_start, 1);
    check("wdt_edge_start_cycle", first_start, 200);

    // Command coincides with watchdog expiry -> one start, both causes.
    apply_reset();
    while (c < 120) begin
      wdt_en_i    = 1'b1;
      cmd_reset_i = (c == 99);
      tick();
    end
    check("dual_n_start", n_start, 1);
    check("dual_start_cycle", first_start, 100);
    check("dual_cause", 32'(cause_o), 5);

    // No downstream response: re-pulse every 5 cycles.
    model_en = 1'b0;
    apply_reset();
    while (c < 25) begin
      cmd_reset_i = (c == 5);
      tick();
    end
    check("repulse_n_start", n_start, 4);
    check("repulse_first", first_start, 6);
    check("repulse_last", last_start, 21);
    check("repulse_cause", 32'(cause_o), 1);
    model_en = 1'b1;

    // Commands during WAIT_RELEASE (15) and HOLDOFF (40) dropped; 70 fires.
    apply_reset();
    while (c < 90) begin
      cmd_reset_i = (c == 5) || (c == 15) || (c == 40) || (c == 70);
      tick();
    end
    check("drop_n_start", n_start, 2);
    check("drop_last_start", last_start, 71);
    check("drop_cause", 32'(cause_o), 1);

    // core_reset_i rising in HOLDOFF (35..39) returns to WAIT_RELEASE.
    apply_reset();
    while (c < 100) begin
      cmd_reset_i = (c == 5);
      tick();
      if (c >= 35 && c < 40) core_reset_i = 1'b1;
    end
    check("reenter_n_start", n_start, 1);
    check("reenter_last_busy", last_busy, 72);

    // Reset while in WAIT_RELEASE, then a fresh command fires normally.
    apply_reset();
    while (c < 40) begin
      cmd_reset_i = (c == 5) || (c == 20);
      reset       = (c == 15);
      tick();
      if (c == 15) begin
        check("midrst_pre_busy", 32'(busy_o), 1);
        check("midrst_pre_cause", 32'(cause_o), 1);
      end
      if (c == 16) begin
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_cause", 32'(cause_o), 0);
        check("midrst_start", 32'(start_o), 0);
      end
    end
    reset = 1'b0;
    check("midrst_n_start", n_start, 2);
    check("midrst_last_start", last_start, 21);
    check("midrst_cause_after", 32'(cause_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
